// File: rtl/vred_seq_ctrl_if.sv
// Bundle of the command, vs2-beat, reduction-unit and result channels of vred_seq_ctrl.
// The sequencer uses the slave side; issue logic and the reduction unit drive the master side.
interface vred_seq_ctrl_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int OPSEL_WIDTH = 3,
    parameter int SEW_WIDTH   = 2,
    parameter int BEATS_WIDTH = 8
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [OPSEL_WIDTH-1:0]  cmd_opSel;
    logic [SEW_WIDTH-1:0]    cmd_sew;
    logic [BEATS_WIDTH-1:0]  cmd_beats;
    logic [DATA_WIDTH-1:0]   cmd_init;

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;

    logic [2*DATA_WIDTH-1:0] red_vec0;
    logic                    red_en;
    logic [SEW_WIDTH-1:0]    red_sew;
    logic [OPSEL_WIDTH-1:0]  red_opSel;
    logic [DATA_WIDTH-1:0]   red_out;

    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;

    modport slave (
        input  cmd_valid, cmd_opSel, cmd_sew, cmd_beats, cmd_init,
        output cmd_ready,
        input  in_valid, in_data,
        output in_ready,
        output red_vec0, red_en, red_sew, red_opSel,
        input  red_out,
        output out_valid, out_data,
        input  out_ready
    );

    modport master (
        output cmd_valid, cmd_opSel, cmd_sew, cmd_beats, cmd_init,
        input  cmd_ready,
        output in_valid, in_data,
        input  in_ready,
        input  red_vec0, red_en, red_sew, red_opSel,
        output red_out,
        input  out_valid, out_data,
        output out_ready
    );
endinterface

// File: rtl/vred_seq_ctrl.sv
// Sequences one vector reduction through the shared single-pair reduction unit:
// accumulate vs2 beats, fold the accumulator down to lane 0, combine with vs1[0].
module vred_seq_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int OPSEL_WIDTH = 3,
    parameter int SEW_WIDTH   = 2,
    parameter int BEATS_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    vred_seq_ctrl_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, LOAD, ACC_ISSUE, ACC_WAIT, FOLD_ISSUE, FOLD_WAIT, FIN_ISSUE, FIN_WAIT, DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [OPSEL_WIDTH-1:0]  op_q;
    logic [SEW_WIDTH-1:0]    sew_q;
    logic [BEATS_WIDTH-1:0]  beats_q;
    logic [BEATS_WIDTH-1:0]  rem_q;
    logic [DATA_WIDTH-1:0]   init_q;
    logic [DATA_WIDTH-1:0]   acc_q;
    logic [1:0]              fold_idx;
    logic [1:0]              fold_cnt;
    logic [DATA_WIDTH-1:0]   fold_hi;
    logic [DATA_WIDTH-1:0]   sew_mask;
    state_t                  fold_entry;

    logic                    cmd_ready;
    logic                    in_ready;
    logic                    red_en;
    logic [2*DATA_WIDTH-1:0] red_vec0;
    logic                    cmd_fire;
    logic                    in_fire;

    assign fold_cnt   = 2'd3 - sew_q[1:0];
    assign sew_mask   = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - (8 << sew_q));
    // A 64b reduction has nothing to fold, so it bypasses FOLD_ISSUE without spending a cycle there.
    assign fold_entry = (fold_cnt == 2'd0) ? FIN_ISSUE : FOLD_ISSUE;
    assign cmd_fire   = bus.cmd_valid && cmd_ready;
    assign in_fire    = bus.in_valid && in_ready;

    always_comb begin
        case (fold_idx)
            2'd0:    fold_hi = acc_q >> (DATA_WIDTH / 2);
            2'd1:    fold_hi = acc_q >> (DATA_WIDTH / 4);
            default: fold_hi = acc_q >> (DATA_WIDTH / 8);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        red_en    = 1'b0;
        red_vec0  = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) state_nxt = (bus.cmd_beats != '0) ? LOAD : DONE;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nxt = (beats_q > 1) ? ACC_ISSUE : fold_entry;
            end
            ACC_ISSUE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    red_en    = 1'b1;
                    red_vec0  = {bus.in_data, acc_q};
                    state_nxt = ACC_WAIT;
                end
            end
            ACC_WAIT:  state_nxt = (rem_q > 1) ? ACC_ISSUE : fold_entry;
            FOLD_ISSUE: begin
                if (fold_cnt == 2'd0) begin
                    state_nxt = FIN_ISSUE;
                end else begin
                    red_en    = 1'b1;
                    red_vec0  = {fold_hi, acc_q};
                    state_nxt = FOLD_WAIT;
                end
            end
            FOLD_WAIT: state_nxt = ((fold_idx + 2'd1) < fold_cnt) ? FOLD_ISSUE : FIN_ISSUE;
            FIN_ISSUE: begin
                red_en    = 1'b1;
                red_vec0  = {init_q, acc_q};
                state_nxt = FIN_WAIT;
            end
            FIN_WAIT:  state_nxt = DONE;
            DONE:      if (bus.out_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        // Nothing may be accepted or issued while reset is held, whatever state we were in.
        if (rst) begin
            cmd_ready = 1'b0;
            in_ready  = 1'b0;
            red_en    = 1'b0;
            red_vec0  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            sew_q    <= '0;
            beats_q  <= '0;
            rem_q    <= '0;
            init_q   <= '0;
            acc_q    <= '0;
            fold_idx <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_fire) begin
                    op_q     <= bus.cmd_opSel;
                    sew_q    <= bus.cmd_sew;
                    beats_q  <= bus.cmd_beats;
                    init_q   <= bus.cmd_init;
                    acc_q    <= bus.cmd_init;
                    fold_idx <= '0;
                end
                LOAD: if (in_fire) begin
                    acc_q <= bus.in_data;
                    rem_q <= beats_q - 1'b1;
                end
                ACC_WAIT: begin
                    acc_q <= bus.red_out;
                    rem_q <= rem_q - 1'b1;
                end
                FOLD_WAIT: begin
                    acc_q    <= bus.red_out;
                    fold_idx <= fold_idx + 2'd1;
                end
                FIN_WAIT: acc_q <= bus.red_out;
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.in_ready  = in_ready;
    assign bus.red_en    = red_en;
    assign bus.red_vec0  = red_vec0;
    assign bus.red_sew   = sew_q;
    assign bus.red_opSel = op_q;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = acc_q & sew_mask;
endmodule

// File: tb/tb_vred_seq_ctrl.sv
// Directed bench for vred_seq_ctrl with a behavioural single-pair reduction unit
// (op 0=sum, 1=minu, 2=min, 3=maxu, 4=max) answering one cycle after each issue.
module tb_vred_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vred_seq_ctrl_if #(.DATA_WIDTH(64), .OPSEL_WIDTH(3), .SEW_WIDTH(2), .BEATS_WIDTH(8)) bus ();

    vred_seq_ctrl #(.DATA_WIDTH(64), .OPSEL_WIDTH(3), .SEW_WIDTH(2), .BEATS_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [63:0] red_model(input logic [127:0] v, input logic [1:0] sew, input logic [2:0] op);
        int unsigned w;
        int unsigned lanes;
        logic [63:0] m, a, b, res, r;
        logic signed [63:0] sa, sb;
        w     = 8 << sew;
        lanes = 64 / w;
        m     = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        r     = '0;
        for (int unsigned i = 0; i < lanes; i++) begin
            a  = (v[63:0] >> (i * w)) & m;
            b  = (v[127:64] >> (i * w)) & m;
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
            case (op)
                3'd0:    res = a + b;
                3'd1:    res = (a < b) ? a : b;
                3'd2:    res = (sa < sb) ? a : b;
                3'd3:    res = (a > b) ? a : b;
                3'd4:    res = (sa > sb) ? a : b;
                default: res = a;
            endcase
            r = r | ((res & m) << (i * w));
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.red_en) bus.red_out <= red_model(bus.red_vec0, bus.red_sew, bus.red_opSel);
    end

    // Drives one command and its beats from a negedge; returns at the negedge where out_valid is seen.
    task automatic run_cmd(input logic [2:0] op, input logic [1:0] sew, input int n, input logic [63:0] init,
                           input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2, input bit toggle,
                           output bit got, output int lat, output int en_cnt, output int ir_cnt,
                           output int hs_cnt, output int cr_cnt, output int wait_cyc, output logic [63:0] data);
        int start;
        int bi;
        got = 1'b0; lat = -1; en_cnt = 0; ir_cnt = 0; hs_cnt = 0; cr_cnt = 0; wait_cyc = 0;
        data = '0; start = -1; bi = 0;
        bus.cmd_opSel = op; bus.cmd_sew = sew; bus.cmd_beats = 8'(n); bus.cmd_init = init;
        bus.cmd_valid = 1'b1;
        #1;
        while (!bus.cmd_ready && wait_cyc < 20) begin
            @(negedge clk); #1; wait_cyc++;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (bus.out_valid) begin
                got  = 1'b1;
                lat  = (start >= 0) ? (cyc - start) : cyc;
                data = bus.out_data;
                break;
            end
            if (bus.cmd_ready) cr_cnt++;
            bus.in_valid = !toggle || (cyc % 2 == 0);
            if (bi >= n)      bus.in_data = 64'hDEAD_BEEF_DEAD_BEEF;
            else if (bi == 0) bus.in_data = b0;
            else if (bi == 1) bus.in_data = b1;
            else              bus.in_data = b2;
            #1;
            if (bus.red_en)   en_cnt++;
            if (bus.in_ready) ir_cnt++;
            if (bus.in_valid && bus.in_ready) begin
                if (bi == 0) start = cyc;
                bi++;
                hs_cnt++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_out(output logic ov, output logic cr);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        ov = bus.out_valid;
        cr = bus.cmd_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_opSel = '0; bus.cmd_sew = '0; bus.cmd_beats = '0; bus.cmd_init = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready_in_rst: got %b want 0", bus.cmd_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.red_en !== 1'b0) begin n_bad++; $display("FAIL reset_red_en: got %b want 0", bus.red_en); end
        n_cmp++; if (bus.out_data !== 64'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        n_cmp++; if (bus.red_vec0 !== 128'h0) begin n_bad++; $display("FAIL reset_red_vec0: got %h want 0", bus.red_vec0); end
    endtask

    task automatic test_sum32();
        bit got; int lat, en, ir, hs, cr, wc; logic [63:0] d; logic ov, crd;
        run_cmd(3'd0, 2'd2, 2, 64'd10, 64'h00000002_00000001, 64'h00000004_00000003, 64'h0, 1'b0,
                got, lat, en, ir, hs, cr, wc, d);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL sum32_timeout: got %b want 1", got); end
        n_cmp++; if (d !== 64'h14) begin n_bad++; $display("FAIL sum32_data: got %h want 14", d); end
        n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL sum32_latency: got %0d want 7", lat); end
        n_cmp++; if (en !== 3) begin n_bad++; $display("FAIL sum32_red_en_count: got %0d want 3", en); end
        n_cmp++; if (hs !== 2) begin n_bad++; $display("FAIL sum32_beats_taken: got %0d want 2", hs); end
        finish_out(ov, crd);
        n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL sum32_out_clear: got %b want 0", ov); end
        n_cmp++; if (crd !== 1'b1) begin n_bad++; $display("FAIL sum32_idle_ready: got %b want 1", crd); end
    endtask

    task automatic test_sum8();
        bit got; int lat, en, ir, hs, cr, wc; logic [63:0] d; logic ov, crd;
        run_cmd(3'd0, 2'd0, 1, 64'h05, 64'h0807060504030201, 64'h0, 64'h0, 1'b0,
                got, lat, en, ir, hs, cr, wc, d);
        n_cmp++; if (d !== 64'h29) begin n_bad++; $display("FAIL sum8_data: got %h want 29", d); end
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL sum8_latency: got %0d want 9", lat); end
        n_cmp++; if (en !== 4) begin n_bad++; $display("FAIL sum8_red_en_count: got %0d want 4", en); end
        n_cmp++; if (hs !== 1) begin n_bad++; $display("FAIL sum8_beats_taken: got %0d want 1", hs); end
        finish_out(ov, crd);
    endtask

    task automatic test_maxu16();
        bit got; int lat, en, ir, hs, cr, wc; logic [63:0] d; logic ov, crd;
        run_cmd(3'd3, 2'd1, 3, 64'h0002, 64'h0001_0010_0100_1000, 64'hFFF0_0002_0003_0004,
                64'h0005_0006_0007_0008, 1'b0, got, lat, en, ir, hs, cr, wc, d);
        n_cmp++; if (d !== 64'hFFF0) begin n_bad++; $display("FAIL maxu16_data: got %h want fff0", d); end
        n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL maxu16_latency: got %0d want 11", lat); end
        n_cmp++; if (en !== 5) begin n_bad++; $display("FAIL maxu16_red_en_count: got %0d want 5", en); end
        n_cmp++; if (hs !== 3) begin n_bad++; $display("FAIL maxu16_beats_taken: got %0d want 3", hs); end
        finish_out(ov, crd);
    endtask

    task automatic test_max16();
        bit got; int lat, en, ir, hs, cr, wc; logic [63:0] d; logic ov, crd;
        run_cmd(3'd4, 2'd1, 2, 64'h8000, 64'h8001_FFF0_FFFE_C000, 64'h9000_FFFC_8000_A000, 64'h0, 1'b0,
                got, lat, en, ir, hs, cr, wc, d);
        n_cmp++; if (d !== 64'hFFFE) begin n_bad++; $display("FAIL max16_data: got %h want fffe", d); end
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL max16_latency: got %0d want 9", lat); end
        finish_out(ov, crd);
    endtask

    task automatic test_zero_beats();
        bit got; int lat, en, ir, hs, cr, wc; logic [63:0] d; logic ov, crd;
        run_cmd(3'd0, 2'd3, 0, 64'h1234, 64'h0, 64'h0, 64'h0, 1'b0, got, lat, en, ir, hs, cr, wc, d);
        n_cmp++; if (d !== 64'h1234) begin n_bad++; $display("FAIL zero64_data: got %h want 1234", d); end
        n_cmp++; if (en !== 0) begin n_bad++; $display("FAIL zero64_red_en_count: got %0d want 0", en); end
        n_cmp++; if (ir !== 0) begin n_bad++; $display("FAIL zero64_in_ready: got %0d want 0", ir); end
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL zero64_latency: got %0d want 0", lat); end
        finish_out(ov, crd);
        run_cmd(3'd0, 2'd0, 0, 64'hABCD, 64'h0, 64'h0, 64'h0, 1'b0, got, lat, en, ir, hs, cr, wc, d);
        n_cmp++; if (d !== 64'hCD) begin n_bad++; $display("FAIL zero8_mask: got %h want cd", d); end
        finish_out(ov, crd);
    endtask

    task automatic test_backpressure();
        bit got; int lat, en, ir, hs, cr, wc; logic [63:0] d; logic ov, crd;
        run_cmd(3'd0, 2'd2, 3, 64'h100, 64'h00000010_00000001, 64'h00000020_00000002,
                64'h00000030_00000003, 1'b1, got, lat, en, ir, hs, cr, wc, d);
        n_cmp++; if (d !== 64'h166) begin n_bad++; $display("FAIL bp_data: got %h want 166", d); end
        n_cmp++; if (en !== 4) begin n_bad++; $display("FAIL bp_red_en_count: got %0d want 4", en); end
        n_cmp++; if (hs !== 3) begin n_bad++; $display("FAIL bp_beats_taken: got %0d want 3", hs); end
        n_cmp++; if (cr !== 0) begin n_bad++; $display("FAIL bp_cmd_ready_busy: got %0d want 0", cr); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, bus.out_valid); end
            n_cmp++; if (bus.out_data !== 64'h166) begin n_bad++; $display("FAIL bp_hold_data[%0d]: got %h want 166", k, bus.out_data); end
            n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_cmd_ready[%0d]: got %b want 0", k, bus.cmd_ready); end
        end
        finish_out(ov, crd);
        n_cmp++; if (crd !== 1'b1) begin n_bad++; $display("FAIL bp_idle_ready: got %b want 1", crd); end
    endtask

    task automatic test_reset_mid();
        bit got; int lat, en, ir, hs, cr, wc; logic [63:0] d; logic ov, crd;
        bus.cmd_opSel = 3'd0; bus.cmd_sew = 2'd0; bus.cmd_beats = 8'd1; bus.cmd_init = 64'h5;
        bus.cmd_valid = 1'b1;
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_accept: got %b want 1", bus.cmd_ready); end
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.in_valid = 1'b1; bus.in_data = 64'h0807060504030201;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.red_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_fold_issue: got %b want 1", bus.red_en); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_cmd_ready_in_rst: got %b want 0", bus.cmd_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.red_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_red_en: got %b want 0", bus.red_en); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle: got %b want 1", bus.cmd_ready); end
        n_cmp++; if (bus.out_data !== 64'h0) begin n_bad++; $display("FAIL rstmid_out_data: got %h want 0", bus.out_data); end
        run_cmd(3'd0, 2'd3, 1, 64'h1, 64'h7, 64'h0, 64'h0, 1'b0, got, lat, en, ir, hs, cr, wc, d);
        n_cmp++; if (d !== 64'h8) begin n_bad++; $display("FAIL rstmid_next_data: got %h want 8", d); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rstmid_next_latency: got %0d want 3", lat); end
        n_cmp++; if (en !== 1) begin n_bad++; $display("FAIL rstmid_next_red_en_count: got %0d want 1", en); end
        finish_out(ov, crd);
    endtask

    task automatic test_back_to_back();
        bit got; int lat, en, ir, hs, cr, wc; logic [63:0] d; logic ov, crd;
        run_cmd(3'd0, 2'd1, 1, 64'h10, 64'h0004_0003_0002_0001, 64'h0, 64'h0, 1'b0,
                got, lat, en, ir, hs, cr, wc, d);
        n_cmp++; if (d !== 64'h1A) begin n_bad++; $display("FAIL b2b_first_data: got %h want 1a", d); end
        n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 7", lat); end
        finish_out(ov, crd);
        run_cmd(3'd1, 2'd0, 2, 64'hF0, 64'h1020304050607080, 64'h111F313F515F7105, 64'h0, 1'b0,
                got, lat, en, ir, hs, cr, wc, d);
        n_cmp++; if (wc !== 0) begin n_bad++; $display("FAIL b2b_accept_wait: got %0d want 0", wc); end
        n_cmp++; if (d !== 64'h05) begin n_bad++; $display("FAIL b2b_minu8_data: got %h want 05", d); end
        n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL b2b_minu8_latency: got %0d want 11", lat); end
        finish_out(ov, crd);
    endtask

    initial begin
        test_reset();
        test_sum32();
        test_sum8();
        test_maxu16();
        test_max16();
        test_zero_beats();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/vred_seq_ctrl.md
Name: vred_seq_ctrl

Overview:
- Sequences one vector reduction (vredsum/vredmin[u]/vredmax[u]) through the shared single-pair reduction unit.
- Per reduction, the block:
  - accepts a command (op, SEW, beat count, scalar init);
  - streams vs2 beats into the unit, accumulating element-wise across beats;
  - folds the accumulator word in halves down to element 0;
  - combines element 0 with the scalar init;
  - returns one SEW-wide result, zero-extended.
- Sits between the vALU issue logic and the reduction unit, and owns that unit exclusively.

Parameters:
- DATA_WIDTH, 64: width of one vs2 beat and of the accumulator; must be 64.
- OPSEL_WIDTH, 3: width of the op select forwarded to the reduction unit.
- SEW_WIDTH, 2: SEW code width. 0=8b, 1=16b, 2=32b, 3=64b.
- BEATS_WIDTH, 8: width of the beat count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_opSel  in  OPSEL_WIDTH  reduction op, latched at command accept.
- cmd_sew  in  SEW_WIDTH  element width, latched at command accept.
- cmd_beats  in  BEATS_WIDTH  number of vs2 beats N, latched at command accept.
- cmd_init  in  DATA_WIDTH  scalar vs1; only element 0 is used.
- in_valid  in  1  vs2 beat valid.
- in_ready  out  1  vs2 beat ready.
- in_data  in  DATA_WIDTH  vs2 beat (packed SEW lanes).
- red_vec0  out  2*DATA_WIDTH  unit operands: {hi, lo}.
- red_en  out  1  unit enable; high on issue cycles.
- red_sew  out  SEW_WIDTH  latched sew.
- red_opSel  out  OPSEL_WIDTH  latched opSel.
- red_out  in  DATA_WIDTH  unit result, valid 1 cycle after issue.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- out_data  out  DATA_WIDTH  element 0 of the result, zero-extended above SEW.

Behaviour:
- Reset (rst high at a clk edge, including mid-operation):
  - state goes to IDLE; any in-flight reduction is dropped.
  - out_valid=0, out_data=0, acc=0, red_en=0, in_ready=0, red_vec0=0.
  - cmd_ready=0 while rst is high, 1 in IDLE afterwards.
- States:
  - IDLE
  - LOAD
  - ACC_ISSUE / ACC_WAIT
  - FOLD_ISSUE / FOLD_WAIT
  - FIN_ISSUE / FIN_WAIT
  - DONE
- IDLE:
  - cmd_valid&cmd_ready latches op, sew, N and init.
  - Next state: LOAD if N>0; DONE with acc=init if N=0.
- LOAD: in_ready=1. On handshake, acc<=in_data, remaining beats <= N-1. Next state is ACC_ISSUE if remaining>0, else FOLD_ISSUE.
- ACC_ISSUE:
  - in_ready=1.
  - red_en=1 and red_vec0={in_data, acc} only in the handshake cycle.
  - Without in_valid, the block stalls with red_en=0.
  - On handshake, go to ACC_WAIT.
- ACC_WAIT: acc<=red_out, remaining decrements. Next state is ACC_ISSUE if remaining>0, else FOLD_ISSUE.
- Fold step count F = 3 - sew (8b:3, 16b:2, 32b:1, 64b:0); step index j starts at 0.
- FOLD_ISSUE:
  - If F=0, skip straight to FIN_ISSUE.
  - Otherwise red_en=1, red_vec0={acc >> (DATA_WIDTH>>(j+1)) zero-filled, acc}, then go to FOLD_WAIT.
- FOLD_WAIT: acc<=red_out, j++. Next state is FOLD_ISSUE while j<F, else FIN_ISSUE.
- Garbage lanes above element 0 are permitted during folding; only lane 0 is architecturally used.
- FIN_ISSUE: red_en=1, red_vec0={init, acc}.
- FIN_WAIT: acc<=red_out, then go to DONE.
- DONE:
  - out_valid=1 and out_data = acc masked to SEW bits; both stay stable until out_ready.
  - On out_valid&out_ready, go to IDLE and clear out_valid.
  - The N=0 path skips FIN: out_data = init element 0.
- red_sew and red_opSel always drive the latched values. red_en=0 outside issue cycles.
- Latency with in_valid held high and N>=1: out_valid is first high at cycle 2(N-1)+2F+3, counting the beat-0 handshake cycle as cycle 0.
- in_ready is never high outside LOAD/ACC_ISSUE. Beats beyond N are never consumed.
- A new command is not accepted until the result handshake completes. Back-to-back commands are accepted the cycle after returning to IDLE.

Test Plan:
- Sum, 32b, N=2:
  - stimulus: beats 0x00000002_00000001 and 0x00000004_00000003, init=10.
  - required: out_data=0x14; out_valid first high at cycle 7.
- Sum, 8b, N=1: beat 0x0807060504030201, init=0x05 -> out_data=0x29 (36+5=41), wrap-free; F=3 fold issues observed on red_en.
- Maxu, 16b, N=3: beats containing lanes 0x0001..0xFFF0, init=0x0002 -> out_data=0xFFF0. Signed max with init=0x8000 and all lanes negative -> largest negative lane.
- N=0, sum, 64b, init=0x1234 -> out_data=0x1234, no red_en pulse, in_ready never high.
- Backpressure:
  - stimulus: in_valid toggles every other cycle; out_ready held low 5 cycles.
  - required: result unchanged and out_valid held; cmd_ready=0 until the out handshake.
- rst asserted during FOLD_WAIT:
  - next cycle: IDLE, out_valid=0, in_ready=0.
  - next command (sum, 64b, N=1, beat 7, init 1) -> out_data=8.
